// File: rtl/alu_mul_seq_pkg.sv
// Shared alu encodings and the multiplier FSM state type.
package kgp_alu_pkg;

  localparam logic       ALU_FNCLASS_ARITH = 1'b0;
  localparam logic       ALU_FN_ADD        = 1'b0;
  localparam logic       ALU_FN_SUB        = 1'b1;
  localparam logic [2:0] ALU_LOGICFN_NONE  = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response bundle between an alu initiator (master) and the alu (slave).
interface alu_mul_seq_if #(
  parameter int unsigned WIDTH = 32
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             fn;
  logic             fnclass;
  logic [2:0]       logicfn;
  logic [WIDTH-1:0] value;
  logic             carry;

  modport master (
    output x, y, fn, fnclass, logicfn,
    input  value, carry
  );

  modport slave (
    input  x, y, fn, fnclass, logicfn,
    output value, carry
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-add WIDTHxWIDTH multiplier using the external shared alu
// for each partial-sum add. One iteration per clock, WIDTH iterations, then
// a one-cycle DONE pulse.
// Optional feature macro: SIGNED_MUL_EN (two's-complement mode via op_signed).
module alu_mul_seq
  import kgp_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 op_signed,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  alu_mul_seq_if.master        alu
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_t           state_q;
  logic [WIDTH-1:0]     hi_q, lo_q, mcand_q;
  logic [WIDTH-1:0]     hi_d, lo_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q, done_q;
  logic [WIDTH-1:0]     alu_x_q, alu_y_q;
  logic                 alu_fn_q;
  logic                 last;
  logic                 s, s0;
  logic                 fn_next;

`ifdef SIGNED_MUL_EN
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);
  logic sgn_q;
`else
  logic unused_op_signed;
  assign unused_op_signed = op_signed;
`endif

  // Next partial product: shift in the alu sum when the multiplier bit is set,
  // otherwise shift the current high half; the top bit carries the sum's sign/carry.
  always_comb begin
    last = (cnt_q == CNT_LAST);
`ifdef SIGNED_MUL_EN
    if (sgn_q) begin
      // Bit W of the sign-extended sum (or difference on the final iteration).
      s       = hi_q[WIDTH-1] ^ (last ? ~mcand_q[WIDTH-1] : mcand_q[WIDTH-1]) ^ alu.carry;
      s0      = hi_q[WIDTH-1];
      fn_next = (cnt_q == CNT_PENULT) ? ALU_FN_SUB : ALU_FN_ADD;
    end else begin
      s       = alu.carry;
      s0      = 1'b0;
      fn_next = ALU_FN_ADD;
    end
`else
    s       = alu.carry;
    s0      = 1'b0;
    fn_next = ALU_FN_ADD;
`endif
    if (lo_q[0]) begin
      hi_d = {s, alu.value[WIDTH-1:1]};
      lo_d = {alu.value[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_d = {s0, hi_q[WIDTH-1:1]};
      lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
    end
  end

  // Control FSM plus datapath registers; alu drive is registered one cycle
  // ahead so it already matches hi/mcand/fn for the ITER cycle it serves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_x_q   <= '0;
      alu_y_q   <= '0;
      alu_fn_q  <= ALU_FN_ADD;
`ifdef SIGNED_MUL_EN
      sgn_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            hi_q     <= '0;
            lo_q     <= op_b;
            mcand_q  <= op_a;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            alu_x_q  <= '0;
            alu_y_q  <= op_a;
            alu_fn_q <= ALU_FN_ADD;
            state_q  <= ITER;
`ifdef SIGNED_MUL_EN
            sgn_q    <= op_signed;
`endif
          end
        end
        ITER: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            product_q <= {hi_d, lo_d};
            done_q    <= 1'b1;
            alu_x_q   <= '0;
            alu_y_q   <= '0;
            alu_fn_q  <= ALU_FN_ADD;
            state_q   <= DONE;
          end else begin
            alu_x_q  <= hi_d;
            alu_y_q  <= mcand_q;
            alu_fn_q <= fn_next;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign product     = product_q;
  assign alu.x       = alu_x_q;
  assign alu.y       = alu_y_q;
  assign alu.fn      = alu_fn_q;
  assign alu.fnclass = ALU_FNCLASS_ARITH;
  assign alu.logicfn = ALU_LOGICFN_NONE;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: models the shared combinational alu, runs a table of
// multiplications, and exercises start-while-busy, mid-operation reset and
// done timing. Signed vectors expect two's-complement results only when
// SIGNED_MUL_EN is defined.
module tb_alu_mul_seq;

  localparam int unsigned W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   op_a, op_b;
  logic           op_signed;
  logic           busy, done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  alu_mul_seq_if #(.WIDTH(W)) alu_bus ();

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_signed (op_signed),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .alu       (alu_bus.master)
  );

  // Reference alu: add, or subtract as x + ~y + 1 with carry = no borrow.
  always_comb begin
    logic [W:0] r;
    if (alu_bus.fn)
      r = {1'b0, alu_bus.x} + {1'b0, ~alu_bus.y} + {{W{1'b0}}, 1'b1};
    else
      r = {1'b0, alu_bus.x} + {1'b0, alu_bus.y};
    alu_bus.value = r[W-1:0];
    alu_bus.carry = r[W];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Waits for done with a cycle budget; returns the cycle index (start cycle = 0).
  task automatic wait_done(output int cyc, output logic busy_ok);
    cyc     = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sg, input logic [2*W-1:0] want);
    int   cyc;
    logic bok;
    op_a = a; op_b = b; op_signed = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_y_first"}, {32'h0, alu_bus.y}, {32'h0, a});
    check({name, "_x_first"}, {32'h0, alu_bus.x}, 64'h0);
    check({name, "_fnclass"}, {61'h0, alu_bus.logicfn, alu_bus.fnclass}, 64'h0);
    wait_done(cyc, bok);
    check({name, "_latency"}, 64'(cyc), 64'd33);
    check({name, "_busy_iter"}, {63'h0, bok}, 64'h1);
    check({name, "_busy_done"}, {63'h0, busy}, 64'h1);
    check({name, "_product"}, product, want);
    @(posedge clk); #1;
    check({name, "_idle"}, {62'h0, busy, done}, 64'h0);
    check({name, "_alu_idle"}, {31'h0, alu_bus.fn, alu_bus.x}, 64'h0);
    check({name, "_hold"}, product, want);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sg;
    logic [2*W-1:0] want;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int   cyc;
    logic bok;

    vecs[0] = '{32'd10,        32'd11,        1'b0, 64'h0000_0000_0000_006E};
    vecs[1] = '{32'd0,         32'd2,         1'b0, 64'h0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[5] = '{32'd2,         32'd0,         1'b0, 64'h0};
    vecs[7] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};
`ifdef SIGNED_MUL_EN
    vecs[3] = '{32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    vecs[8] = '{32'd7,         32'hFFFF_FFFA, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6};
`else
    vecs[3] = '{32'hFFFF_FFFD, 32'd5,         1'b1, 64'h0000_0004_FFFF_FFF1};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001};
    vecs[8] = '{32'd7,         32'hFFFF_FFFA, 1'b1, 64'h0000_0006_FFFF_FFD6};
`endif

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_done", {62'h0, busy, done}, 64'h0);
    check("rst_product", product, 64'h0);
    check("rst_alu", {31'h0, alu_bus.fn, alu_bus.x}, 64'h0);
    check("rst_alu_y", {32'h0, alu_bus.y}, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].want);

    // Start pulses and operand changes mid-operation must be ignored.
    op_a = 32'd10; op_b = 32'd11; op_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    op_a = 32'd99; op_b = 32'd77; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 7;
    bok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) bok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_start_latency", 64'(cyc), 64'd33);
    check("busy_start_product", product, 64'h6E);
    // Start raised in the DONE cycle is dropped, not queued.
    op_a = 32'd3; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_start_ignored", {63'h0, busy}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("done_start_noqueue", {62'h0, busy, done}, 64'h0);
    check("done_start_product", product, 64'h6E);

    // Asynchronous reset around iteration 10 aborts and clears the product.
    op_a = 32'd12345; op_b = 32'd678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {62'h0, busy, done}, 64'h0);
    check("midrst_product", product, 64'h0);
    check("midrst_alu", {31'h0, alu_bus.fn, alu_bus.x}, 64'h0);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_stays_idle", {62'h0, busy, done}, 64'h0);
    run_op("after_rst", 32'd10, 32'd11, 1'b0, 64'h6E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
